// File: rtl/ex_stage_pkg.sv
// Shared types and opcode/result-class encodings for the execute stage.
// Encodings mirror the decode stage's opcode table so both ends agree on aluop/alusel.
package ex_stage_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    RES_NOP   = 3'b000,
    RES_LOGIC = 3'b001,
    RES_SHIFT = 3'b010,
    RES_MOVE  = 3'b011
  } alu_res_t;

  localparam logic [7:0] OP_NOP  = 8'b0000_0000;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO = 8'b0001_0011;

  typedef struct packed {
    logic                  wreg;
    logic [REG_ADDR_W-1:0] wd;
    logic [REG_W-1:0]      wdata;
  } ex_mem_t;

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute instruction bundle; decode drives it, execute consumes it.
interface ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [7:0]        aluop;
  logic [2:0]        alusel;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [ADDR_W-1:0] wd;
  logic              wreg;

  modport master (output aluop, alusel, reg1, reg2, wd, wreg);
  modport slave  (input  aluop, alusel, reg1, reg2, wd, wreg);
endinterface

// File: rtl/ex_stage_hilo_reg.sv
// Architectural HI/LO register pair; write enables arrive already qualified by the pipeline.
module hilo_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_hi,
  input  logic              we_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      if (we_hi) hi_o <= wdata;
      if (we_lo) lo_o <= wdata;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move result, combinational forwarding to decode,
// EX/MEM pipeline register and ownership of HI/LO.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  ex_stage_if.slave         dif,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              ex_wreg_o,
  output logic [ADDR_W-1:0] ex_wd_o,
  output logic [DATA_W-1:0] ex_wdata_o,
  output logic              mem_wreg_o,
  output logic [ADDR_W-1:0] mem_wd_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] result_p0;
  logic              vld_p0;
  ex_mem_t           ex_mem_p1;
  logic              hilo_we;

  // Only reg1[4:0] sets the amount; SRA replicates reg2's sign bit.
  function automatic logic [DATA_W-1:0] shift_op(input logic [7:0]        op,
                                                 input logic [DATA_W-1:0] val,
                                                 input logic [4:0]        shamt);
    logic signed [DATA_W-1:0] sval;
    sval = signed'(val);
    case (op)
      OP_SLL:  shift_op = val << shamt;
      OP_SRL:  shift_op = val >> shamt;
      OP_SRA:  shift_op = sval >>> shamt;
      default: shift_op = '0;
    endcase
  endfunction

  // ---- p0: combinational result and forwarding ----
  always_comb begin
    result_p0 = '0;
    case (dif.alusel)
      RES_LOGIC: begin
        case (dif.aluop)
          OP_OR:   result_p0 = dif.reg1 | dif.reg2;
          OP_AND:  result_p0 = dif.reg1 & dif.reg2;
          OP_XOR:  result_p0 = dif.reg1 ^ dif.reg2;
          OP_NOR:  result_p0 = ~(dif.reg1 | dif.reg2);
          default: result_p0 = '0;
        endcase
      end
      RES_SHIFT: result_p0 = shift_op(dif.aluop, dif.reg2, dif.reg1[4:0]);
      RES_MOVE: begin
        case (dif.aluop)
          OP_MFHI:         result_p0 = hi_o;
          OP_MFLO:         result_p0 = lo_o;
          OP_MOVN, OP_MOVZ: result_p0 = dif.reg1;
          default:         result_p0 = '0;
        endcase
      end
      default: result_p0 = '0;
    endcase
  end

  // Writes to $0 are dropped here so decode never forwards a stale zero register.
  assign vld_p0     = !rst && dif.wreg && (dif.wd != '0) && !flush_i;
  assign ex_wreg_o  = vld_p0;
  assign ex_wd_o    = rst ? '0 : dif.wd;
  assign ex_wdata_o = rst ? '0 : result_p0;

  // ---- p1: EX/MEM register (rst > flush > stall > load) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_p1 <= '0;
    end else if (flush_i) begin
      ex_mem_p1 <= '0;
    end else if (!stall_i) begin
      ex_mem_p1 <= '{wreg: vld_p0, wd: ex_wd_o, wdata: ex_wdata_o};
    end
  end

  assign mem_wreg_o  = ex_mem_p1.wreg;
  assign mem_wd_o    = ex_mem_p1.wd;
  assign mem_wdata_o = ex_mem_p1.wdata;

  // HI/LO commit on exactly the edges where EX/MEM loads.
  assign hilo_we = !rst && !flush_i && !stall_i;

  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .clk   (clk),
    .rst   (rst),
    .we_hi (hilo_we && (dif.aluop == OP_MTHI)),
    .we_lo (hilo_we && (dif.aluop == OP_MTLO)),
    .wdata (dif.reg1),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a reference model predicts each edge's EX/MEM and HI/LO
// state into a scoreboard queue that is popped and compared after the edge.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        ex_wreg, mem_wreg;
  logic [4:0]  ex_wd, mem_wd;
  logic [31:0] ex_wdata, mem_wdata, hi, lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  logic        m_wreg = 1'b0;
  logic [4:0]  m_wd = '0;
  logic [31:0] m_wdata = '0, m_hi = '0, m_lo = '0;
  logic [31:0] last_ex;

  ex_stage_if #(.DATA_W(32), .ADDR_W(5)) dif ();

  ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .dif(dif), .stall_i(stall), .flush_i(flush),
    .ex_wreg_o(ex_wreg), .ex_wd_o(ex_wd), .ex_wdata_o(ex_wdata),
    .mem_wreg_o(mem_wreg), .mem_wd_o(mem_wd), .mem_wdata_o(mem_wdata),
    .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    model_res = 32'h0;
    if (sel == 3'b001) begin
      if (op == OP_OR)  model_res = a | b;
      if (op == OP_AND) model_res = a & b;
      if (op == OP_XOR) model_res = a ^ b;
      if (op == OP_NOR) model_res = ~(a | b);
    end else if (sel == 3'b010) begin
      ext = {{32{b[31]}}, b} >> a[4:0];
      if (op == OP_SLL) model_res = b << a[4:0];
      if (op == OP_SRL) model_res = b >> a[4:0];
      if (op == OP_SRA) model_res = ext[31:0];
    end else if (sel == 3'b011) begin
      if (op == OP_MFHI) model_res = m_hi;
      if (op == OP_MFLO) model_res = m_lo;
      if (op == OP_MOVN || op == OP_MOVZ) model_res = a;
    end
  endfunction

  // One instruction per cycle: drive, check forwarding at negedge, predict, check after edge.
  task automatic step(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [4:0] d, input logic w,
                      input logic st, input logic fl, input logic rs);
    exp_t        e;
    logic        ew;
    logic [4:0]  ed;
    logic [31:0] ev;
    dif.aluop = op; dif.alusel = sel; dif.reg1 = r1; dif.reg2 = r2;
    dif.wd = d; dif.wreg = w; stall = st; flush = fl; rst = rs;
    @(negedge clk);
    ev = rs ? 32'h0 : model_res(op, sel, r1, r2);
    ew = !rs && w && (d != 5'd0) && !fl;
    ed = rs ? 5'd0 : d;
    last_ex = ex_wdata;
    chk("ex_wreg", {31'h0, ex_wreg}, {31'h0, ew});
    chk("ex_wd", {27'h0, ex_wd}, {27'h0, ed});
    chk("ex_wdata", ex_wdata, ev);
    if (rs) begin
      m_wreg = 1'b0; m_wd = '0; m_wdata = '0; m_hi = '0; m_lo = '0;
    end else if (fl) begin
      m_wreg = 1'b0; m_wd = '0; m_wdata = '0;
    end else if (!st) begin
      m_wreg = ew; m_wd = ed; m_wdata = ev;
      if (op == OP_MTHI) m_hi = r1;
      if (op == OP_MTLO) m_lo = r1;
    end
    sb.push_back('{wreg: m_wreg, wd: m_wd, wdata: m_wdata, hi: m_hi, lo: m_lo});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      chk("mem_wreg", {31'h0, mem_wreg}, {31'h0, e.wreg});
      chk("mem_wd", {27'h0, mem_wd}, {27'h0, e.wd});
      chk("mem_wdata", mem_wdata, e.wdata);
      chk("hi", hi, e.hi);
      chk("lo", lo, e.lo);
    end
  endtask

  initial begin
    dif.aluop = OP_NOP; dif.alusel = 3'b000; dif.reg1 = '0; dif.reg2 = '0;
    dif.wd = '0; dif.wreg = 1'b0; stall = 1'b0; flush = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    step(OP_OR, 3'b001, 32'h1111_1111, 32'h2222_2222, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("reset_ex_wdata", last_ex, 32'h0);
    chk("reset_hi", hi, 32'h0);

    step(OP_OR, 3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("or_const", last_ex, 32'hF0F0_0F0F);
    chk("or_mem_const", mem_wdata, 32'hF0F0_0F0F);
    step(OP_AND, 3'b001, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_XOR, 3'b001, 32'hAAAA_5555, 32'hFFFF_0000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_NOR, 3'b001, 32'h0000_00F0, 32'h0000_000F, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);

    step(OP_SRA, 3'b010, 32'd4, 32'h8000_0000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sra_const", last_ex, 32'hF800_0000);
    step(OP_SRL, 3'b010, 32'd4, 32'h8000_0000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("srl_const", last_ex, 32'h0800_0000);
    step(OP_SRL, 3'b010, 32'h25, 32'h8000_0000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("srl_amt_mask", last_ex, 32'h0400_0000);
    step(OP_SLL, 3'b010, 32'hFFFF_FFE3, 32'h0000_0001, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_SRA, 3'b010, 32'd31, 32'h7FFF_FFFF, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);

    step(OP_MTHI, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_MFHI, 3'b011, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mfhi_const", last_ex, 32'hDEAD_BEEF);
    chk("lo_untouched", lo, 32'h0);
    step(OP_MTLO, 3'b000, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_MFLO, 3'b011, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_MOVN, 3'b011, 32'hCAFE_0001, 32'h1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++)
      step(OP_MTLO, 3'b000, 32'hCAFE_F00D, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_lo_held", lo, 32'h1234_5678);
    chk("stall_mem_held", mem_wdata, 32'hCAFE_0001);
    step(OP_MTLO, 3'b000, 32'hCAFE_F00D, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_NOP, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mtlo_once", lo, 32'hCAFE_F00D);

    step(OP_OR, 3'b001, 32'h0000_0003, 32'h0000_0004, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_OR, 3'b001, 32'h0000_00F0, 32'h0000_000F, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_stall_wd", {27'h0, mem_wd}, 32'h0);
    step(OP_MTHI, 3'b000, 32'h5555_AAAA, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(OP_MTHI, 3'b000, 32'h0BAD_0BAD, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_no_hi", hi, 32'hDEAD_BEEF);

    step(OP_OR, 3'b001, 32'h0000_0001, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wd0_mem_wreg", {31'h0, mem_wreg}, 32'h0);
    step(OP_XOR, 3'b001, 32'h1, 32'h2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_SLL, 3'b001, 32'h1, 32'h2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_OR, 3'b111, 32'h1, 32'h2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    step(OP_MTLO, 3'b000, 32'h7777_7777, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(OP_OR, 3'b001, 32'hFFFF_FFFF, 32'h0, 5'd20, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_lo", lo, 32'h0);
    chk("rst_mid_hi", hi, 32'h0);
    step(OP_OR, 3'b001, 32'h0000_00A0, 32'h0000_000B, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
